// File: rtl/alu_pipe_responder.sv
// Two-stage pipelined ALU responder: stage 1 captures {opcode,a,b}, stage 2 registers the result.
// Both stages advance on a shared ready chain so the consumer can apply full backpressure.
package alu_pipe_pkg;
  typedef enum logic [1:0] {
    ADD            = 2'd0,
    SUB            = 2'd1,
    BITWISE_INVERT = 2'd2,
    REDUCTION_OR   = 2'd3
  } opcode_e;
endpackage

module alu_pipe_responder
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  opcode_e              opcode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     c,
  output logic                 carry,
  output opcode_e              rsp_opcode,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 s1_valid_reg;
  opcode_e              s1_opcode_reg;
  logic [WIDTH-1:0]     s1_a_reg;
  logic [WIDTH-1:0]     s1_b_reg;
  logic                 s2_valid_reg;
  logic [WIDTH-1:0]     c_reg;
  logic                 carry_reg;
  opcode_e              rsp_opcode_reg;
  logic [CNT_WIDTH-1:0] op_count_reg;

  logic             s2_adv;
  logic             s1_adv;
  logic             req_fire;
  logic             rsp_fire;
  logic [WIDTH:0]   res_next;

  // Ready chain: stage 2 frees when empty or drained; stage 1 frees when empty or can pass on.
  assign s2_adv    = !s2_valid_reg || rsp_ready;
  assign s1_adv    = s1_valid_reg && s2_adv;
  assign req_ready = !s1_valid_reg || s2_adv;
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = s2_valid_reg && rsp_ready;

  // Execute on WIDTH+1 bits so the top bit is carry for ADD and borrow for SUB.
  always_comb begin
    res_next = '0;
    case (s1_opcode_reg)
      SUB:            res_next = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
      BITWISE_INVERT: res_next = {1'b0, ~s1_a_reg};
      REDUCTION_OR:   res_next = {{WIDTH{1'b0}}, |s1_b_reg};
      default:        res_next = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_opcode_reg <= ADD;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
    end else if (req_fire) begin
      s1_valid_reg  <= 1'b1;
      s1_opcode_reg <= opcode;
      s1_a_reg      <= a;
      s1_b_reg      <= b;
    end else if (s1_adv) begin
      s1_valid_reg  <= 1'b0;
    end
  end

  // Result registers only load on advance, so c holds its last value once the pipe empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg   <= 1'b0;
      c_reg          <= '0;
      carry_reg      <= 1'b0;
      rsp_opcode_reg <= ADD;
    end else if (s1_adv) begin
      s2_valid_reg   <= 1'b1;
      c_reg          <= res_next[WIDTH-1:0];
      carry_reg      <= res_next[WIDTH];
      rsp_opcode_reg <= s1_opcode_reg;
    end else if (rsp_ready) begin
      s2_valid_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (rsp_fire && (op_count_reg != CNT_MAX)) begin
      op_count_reg <= op_count_reg + 1'b1;
    end
  end

  assign rsp_valid  = s2_valid_reg;
  assign c          = c_reg;
  assign carry      = carry_reg;
  assign rsp_opcode = rsp_opcode_reg;
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_pipe_responder.sv
// Self-checking bench for alu_pipe_responder: table vectors plus streamed traffic,
// all results checked through an in-order scoreboard queue.
module tb_alu_pipe_responder;
  import alu_pipe_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  opcode_e       opcode = ADD;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  c;
  logic          carry;
  opcode_e       rsp_opcode;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_pipe_responder #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .c          (c),
    .carry      (carry),
    .rsp_opcode (rsp_opcode),
    .op_count   (op_count)
  );

  typedef struct {
    opcode_e  op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_c;
    logic       exp_carry;
  } vec_t;

  typedef struct {
    opcode_e    op;
    logic [3:0] c;
    logic       carry;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  exp_t prev_rsp;
  bit   prev_stall = 1'b0;
  bit   last_rsp   = 1'b0;
  int   rsp_cnt    = 0;
  int   n_cmp      = 0;
  int   n_err      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic written independently in integer terms.
  function automatic exp_t model(input opcode_e op, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    int   s;
    e.op    = op;
    e.carry = 1'b0;
    case (op)
      ADD: begin
        s = int'(x) + int'(y);
        e.c = 4'(s % 16);
        e.carry = (s >= 16);
      end
      SUB: begin
        s = int'(x) - int'(y) + 16;
        e.c = 4'(s % 16);
        e.carry = (x < y);
      end
      BITWISE_INVERT: e.c = 4'(15 - int'(x));
      default:        e.c = (y != 0) ? 4'd1 : 4'd0;
    endcase
    return e;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle(output bit fired);
    exp_t e;
    @(negedge clk);
    fired    = 1'b0;
    last_rsp = 1'b0;
    if (!rst) begin
      if (prev_stall)
        check("hold_stable", {rsp_valid, rsp_opcode, carry, c},
              {1'b1, prev_rsp.op, prev_rsp.carry, prev_rsp.c});
      fired = req_valid && req_ready;
      if (rsp_valid && rsp_ready) begin
        last_rsp = 1'b1;
        rsp_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got op=%0d c=%0h carry=%0b expected no response",
                   rsp_opcode, c, carry);
        end else begin
          e = sb.pop_front();
          $display("rsp #%0d op=%0d c=%0h carry=%0b", rsp_cnt, rsp_opcode, c, carry);
          check("rsp_data", {rsp_opcode, carry, c}, {e.op, e.carry, e.c});
        end
      end
      prev_stall     = rsp_valid && !rsp_ready;
      prev_rsp.op    = rsp_opcode;
      prev_rsp.c     = c;
      prev_rsp.carry = carry;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; mode 1: stalled for 'hold' cycles; mode 2: ready toggles.
  task automatic stream(input int n, input int mode, input int hold);
    opcode_e    ops[32];
    logic [3:0] as[32];
    logic [3:0] bs[32];
    int         idx = 0;
    int         cyc = 0;
    int         start = rsp_cnt;
    bit         f;
    for (int i = 0; i < n; i++) begin
      ops[i] = opcode_e'($urandom_range(0, 3));
      as[i]  = 4'($urandom_range(0, 15));
      bs[i]  = 4'($urandom_range(0, 15));
    end
    while ((idx < n || sb.size() != 0) && cyc < 300) begin
      if (mode == 1 && cyc == hold) begin
        check("full_accepted", idx, 2);
        check("full_req_ready", req_ready, 0);
      end
      req_valid = (idx < n);
      if (idx < n) begin
        opcode = ops[idx];
        a      = as[idx];
        b      = bs[idx];
      end
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = (cyc >= hold);
        default: rsp_ready = (cyc % 2 == 0);
      endcase
      cycle(f);
      if (f) begin
        sb.push_back(model(opcode, a, b));
        idx++;
      end
      cyc++;
    end
    req_valid = 1'b0;
    check("stream_drained", (idx == n && sb.size() == 0), 1);
    check("stream_count", rsp_cnt - start, n);
  endtask

  initial begin
    bit f;
    int lat;
    int idx;
    int cyc;
    int n_fire;
    opcode_e op;

    vecs[0] = '{ADD,            4'h2, 4'h1, 4'h3, 1'b0};
    vecs[1] = '{SUB,            4'h2, 4'h1, 4'h1, 1'b0};
    vecs[2] = '{BITWISE_INVERT, 4'h2, 4'h1, 4'hD, 1'b0};
    vecs[3] = '{REDUCTION_OR,   4'h2, 4'h1, 4'h1, 1'b0};
    vecs[4] = '{ADD,            4'hF, 4'h1, 4'h0, 1'b1};
    vecs[5] = '{REDUCTION_OR,   4'h5, 4'h0, 4'h0, 1'b0};
    vecs[6] = '{SUB,            4'h2, 4'h1, 4'h1, 1'b0};
    vecs[7] = '{SUB,            4'h1, 4'h2, 4'hF, 1'b1};

    rst = 1'b1;
    cycle(f);
    cycle(f);
    rst = 1'b0;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_c", c, 0);
    check("reset_carry", carry, 0);
    check("reset_rsp_opcode", rsp_opcode, ADD);
    check("reset_op_count", op_count, 0);
    check("reset_req_ready", req_ready, 1);

    // Opcode walk with latency measured from the accept cycle.
    op = ADD;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      opcode    = op;
      a         = vecs[i].a;
      b         = vecs[i].b;
      rsp_ready = 1'b1;
      cycle(f);
      check("walk_accept", f, 1);
      if (f) sb.push_back('{vecs[i].op, vecs[i].exp_c, vecs[i].exp_carry});
      req_valid = 1'b0;
      lat = 0;
      while (lat < 6) begin
        cycle(f);
        lat++;
        if (last_rsp) break;
      end
      check("walk_latency", lat, 2);
      op = op.next();
    end
    check("walk_op_count", op_count, 4);

    // Arithmetic corner vectors back to back.
    idx = 4;
    cyc = 0;
    while ((idx < 8 || sb.size() != 0) && cyc < 40) begin
      req_valid = (idx < 8);
      if (idx < 8) begin
        opcode = vecs[idx].op;
        a      = vecs[idx].a;
        b      = vecs[idx].b;
      end
      rsp_ready = 1'b1;
      cycle(f);
      if (f) begin
        sb.push_back('{vecs[idx].op, vecs[idx].exp_c, vecs[idx].exp_carry});
        idx++;
      end
      cyc++;
    end
    req_valid = 1'b0;
    check("table_drained", (idx == 8 && sb.size() == 0), 1);
    cycle(f);
    check("empty_rsp_valid", rsp_valid, 0);
    check("empty_c_hold", c, vecs[7].exp_c);

    stream(6, 1, 5);
    stream(10, 2, 0);

    // Reset with two operations in flight.
    rsp_ready = 1'b0;
    n_fire = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      opcode    = opcode_e'($urandom_range(0, 3));
      a         = 4'($urandom_range(0, 15));
      b         = 4'($urandom_range(0, 15));
      cycle(f);
      if (f) n_fire++;
    end
    check("inflight_accepted", n_fire, 2);
    req_valid = 1'b0;
    rst = 1'b1;
    cycle(f);
    rst = 1'b0;
    sb.delete();
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_req_ready", req_ready, 1);
    idx = rsp_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(f);
    check("midrst_no_stale", rsp_cnt - idx, 0);

    // Counter saturation: 17 responses into a 4-bit counter.
    stream(17, 0, 0);
    check("sat_op_count", op_count, 15);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(f);
    check("sat_op_count_hold", op_count, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
